// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: decides when the MAC transmit engine starts a client
// frame or a locally requested pause frame. Honours received pause time,
// inter-frame gap, link faults and an acknowledge timeout.
module tx_frame_scheduler #(
  parameter int QUANTUM_CYCLES = 8,
  parameter int ACK_TIMEOUT    = 64
) (
  input  logic        TX_CLK,
  input  logic        RESET,
  input  logic        CLIENT_REQ,
  input  logic        PAUSE_REQ,
  input  logic [15:0] PAUSE_DATA,
  input  logic        FC_TX_PAUSEVALID,
  input  logic [15:0] FC_TX_PAUSEDATA,
  input  logic [7:0]  TX_IFG_DELAY,
  input  logic        TX_ACK,
  input  logic        FRAME_DONE,
  input  logic        LOCALLINKFAULT,
  input  logic        RXTXLINKFAULT,
  output logic        TX_START,
  output logic        CLIENT_GRANT,
  output logic        FC_TRANS_PAUSEVAL,
  output logic [15:0] FC_TRANS_PAUSEDATA,
  output logic        PAUSED,
  output logic        BUSY,
  output logic        TIMEOUT
);

  localparam int AW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, START_CLIENT, WAIT_ACK, START_PAUSE, ACTIVE, IFG
  } state_t;

  state_t        state_reg, state_next;
  logic          pend_reg, pend_next;
  logic [15:0]   pdata_reg, pdata_next;
  logic [18:0]   pause_cnt_reg, pause_cnt_next;
  logic [7:0]    ifg_cnt_reg, ifg_cnt_next;
  logic [AW-1:0] ack_cnt_reg, ack_cnt_next;
  logic          tx_start_reg, grant_reg, grant_next;
  logic          fc_val_reg, paused_reg, busy_reg;
  logic          timeout_reg, timeout_next;
  logic [15:0]   fc_data_reg, fc_data_next;

  logic          fault;
  logic          pend_any;
  logic [15:0]   pend_data;
  logic [18:0]   pause_load;

  // A request arriving this very cycle counts as pending, so a pause request
  // coinciding with a client request in IDLE still goes out first.
  assign fault      = LOCALLINKFAULT | RXTXLINKFAULT;
  assign pend_any   = pend_reg | PAUSE_REQ;
  assign pend_data  = PAUSE_REQ ? PAUSE_DATA : pdata_reg;
  assign pause_load = 19'(FC_TX_PAUSEDATA) * 19'(QUANTUM_CYCLES);

  // Next-state logic, IFG / ack-wait counters and single-cycle pulse requests
  always_comb begin
    state_next   = state_reg;
    ifg_cnt_next = ifg_cnt_reg;
    ack_cnt_next = ack_cnt_reg;
    grant_next   = 1'b0;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fault) begin
          if (pend_any)                     state_next = START_PAUSE;
          else if (CLIENT_REQ && !paused_reg) state_next = START_CLIENT;
        end
      end
      START_CLIENT: begin
        ack_cnt_next = '0;
        state_next   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (TX_ACK) begin
          grant_next = 1'b1;
          state_next = ACTIVE;
        end else if (ack_cnt_reg == AW'(ACK_TIMEOUT - 1)) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          ack_cnt_next = ack_cnt_reg + 1'b1;
        end
      end
      START_PAUSE: state_next = ACTIVE;
      ACTIVE: begin
        if (FRAME_DONE) begin
          ifg_cnt_next = TX_IFG_DELAY;
          state_next   = IFG;
        end
      end
      IFG: begin
        // A captured gap of 0 or 1 both spend exactly one cycle here.
        if (ifg_cnt_reg <= 8'd1) begin
          ifg_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          ifg_cnt_next = ifg_cnt_reg - 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending pause-frame request: consumed when START_PAUSE is entered
  always_comb begin
    pend_next    = pend_reg;
    pdata_next   = pdata_reg;
    fc_data_next = '0;
    if (state_next == START_PAUSE) begin
      pend_next    = 1'b0;
      fc_data_next = pend_data;
    end else if (PAUSE_REQ) begin
      pend_next  = 1'b1;
      pdata_next = PAUSE_DATA;
    end
  end

  // Received-pause countdown: a load always wins over the decrement
  always_comb begin
    pause_cnt_next = pause_cnt_reg;
    if (FC_TX_PAUSEVALID)           pause_cnt_next = pause_load;
    else if (pause_cnt_reg != '0)   pause_cnt_next = pause_cnt_reg - 19'd1;
  end

  // State, counters and registered outputs
  always_ff @(posedge TX_CLK or posedge RESET) begin
    if (RESET) begin
      state_reg     <= IDLE;
      pend_reg      <= 1'b0;
      pdata_reg     <= '0;
      pause_cnt_reg <= '0;
      ifg_cnt_reg   <= '0;
      ack_cnt_reg   <= '0;
      tx_start_reg  <= 1'b0;
      grant_reg     <= 1'b0;
      fc_val_reg    <= 1'b0;
      fc_data_reg   <= '0;
      paused_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pend_reg      <= pend_next;
      pdata_reg     <= pdata_next;
      pause_cnt_reg <= pause_cnt_next;
      ifg_cnt_reg   <= ifg_cnt_next;
      ack_cnt_reg   <= ack_cnt_next;
      tx_start_reg  <= (state_next == START_CLIENT);
      grant_reg     <= grant_next;
      fc_val_reg    <= (state_next == START_PAUSE);
      fc_data_reg   <= fc_data_next;
      paused_reg    <= (pause_cnt_next != '0);
      busy_reg      <= (state_next != IDLE);
      timeout_reg   <= timeout_next;
    end
  end

  assign TX_START           = tx_start_reg;
  assign CLIENT_GRANT       = grant_reg;
  assign FC_TRANS_PAUSEVAL  = fc_val_reg;
  assign FC_TRANS_PAUSEDATA = fc_data_reg;
  assign PAUSED             = paused_reg;
  assign BUSY               = busy_reg;
  assign TIMEOUT            = timeout_reg;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Testbench for tx_frame_scheduler: randomized engine/client stimulus, with
// expected output pulses queued at issue time and checked by a monitor.
module tb_tx_frame_scheduler;

  localparam int Q  = 8;
  localparam int TO = 64;

  logic        TX_CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CLIENT_REQ = 1'b0;
  logic        PAUSE_REQ = 1'b0;
  logic [15:0] PAUSE_DATA = '0;
  logic        FC_TX_PAUSEVALID = 1'b0;
  logic [15:0] FC_TX_PAUSEDATA = '0;
  logic [7:0]  TX_IFG_DELAY = '0;
  logic        TX_ACK = 1'b0;
  logic        FRAME_DONE = 1'b0;
  logic        LOCALLINKFAULT = 1'b0;
  logic        RXTXLINKFAULT = 1'b0;
  logic        TX_START, CLIENT_GRANT, FC_TRANS_PAUSEVAL, PAUSED, BUSY, TIMEOUT;
  logic [15:0] FC_TRANS_PAUSEDATA;

  tx_frame_scheduler #(.QUANTUM_CYCLES(Q), .ACK_TIMEOUT(TO)) dut (
    .TX_CLK(TX_CLK), .RESET(RESET), .CLIENT_REQ(CLIENT_REQ),
    .PAUSE_REQ(PAUSE_REQ), .PAUSE_DATA(PAUSE_DATA),
    .FC_TX_PAUSEVALID(FC_TX_PAUSEVALID), .FC_TX_PAUSEDATA(FC_TX_PAUSEDATA),
    .TX_IFG_DELAY(TX_IFG_DELAY), .TX_ACK(TX_ACK), .FRAME_DONE(FRAME_DONE),
    .LOCALLINKFAULT(LOCALLINKFAULT), .RXTXLINKFAULT(RXTXLINKFAULT),
    .TX_START(TX_START), .CLIENT_GRANT(CLIENT_GRANT),
    .FC_TRANS_PAUSEVAL(FC_TRANS_PAUSEVAL), .FC_TRANS_PAUSEDATA(FC_TRANS_PAUSEDATA),
    .PAUSED(PAUSED), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
  );

  always #5 TX_CLK = ~TX_CLK;

  int cyc = 0;
  always @(posedge TX_CLK) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  bit mon_en = 1'b0;

  // Expected output pulses, in time order
  localparam int EV_START = 0, EV_GRANT = 1, EV_PAUSE = 2, EV_TIMEOUT = 3;
  typedef struct { int kind; int at; int data; } ev_t;
  ev_t exp_q[$];

  // Received-pause model: PAUSED is high on cycles [lo, hi]; a load at cycle
  // chg_cyc takes effect from the following cycle.
  int old_lo = 1, old_hi = 0, new_lo = 1, new_hi = 0, chg_cyc = 0;

  function automatic string kname(input int k);
    case (k)
      EV_START:   return "TX_START";
      EV_GRANT:   return "CLIENT_GRANT";
      EV_PAUSE:   return "FC_TRANS_PAUSEVAL";
      default:    return "TIMEOUT";
    endcase
  endfunction

  task automatic expect_ev(input int kind, input int at, input int data);
    ev_t e;
    e.kind = kind; e.at = at; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  task automatic see_ev(input int kind, input int data);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL event: unexpected %s data=%0d @cyc %0d", kname(kind), data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.at != cyc || e.data != data) begin
        fails++;
        $display("FAIL event: got %s data=%0d @cyc %0d, required %s data=%0d @cyc %0d",
                 kname(kind), data, cyc, kname(e.kind), e.data, e.at);
      end
    end
  endtask

  // Monitor: PAUSED against the model every cycle, and every output pulse
  // against the head of the expectation queue.
  always @(negedge TX_CLK) begin : monitor
    int ep;
    if (mon_en && !RESET) begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        tests++; fails++;
        $display("FAIL event: missing %s data=%0d due @cyc %0d", kname(exp_q[0].kind),
                 exp_q[0].data, exp_q[0].at);
        void'(exp_q.pop_front());
      end
      if (cyc > chg_cyc) ep = (cyc >= new_lo && cyc <= new_hi) ? 1 : 0;
      else               ep = (cyc >= old_lo && cyc <= old_hi) ? 1 : 0;
      chk("paused", int'(PAUSED), ep);
      if (!FC_TRANS_PAUSEVAL) chk("pausedata_idle", int'(FC_TRANS_PAUSEDATA), 0);
      if (TX_START)          see_ev(EV_START, 0);
      if (CLIENT_GRANT)      see_ev(EV_GRANT, 0);
      if (FC_TRANS_PAUSEVAL) see_ev(EV_PAUSE, int'(FC_TRANS_PAUSEDATA));
      if (TIMEOUT)           see_ev(EV_TIMEOUT, 0);
    end
  end

  task automatic step();
    @(posedge TX_CLK); #1;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  function automatic int urand(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  task automatic wait_start(output int s);
    bit got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge TX_CLK);
      if (TX_START) got = 1'b1;
    end
    s = cyc;
    if (!got) begin
      tests++; fails++;
      $display("FAIL wait_start: no TX_START within 3000 cycles, required one");
    end
  endtask

  // Received pause frame with q quanta, issued this cycle
  task automatic set_pause(input int q);
    old_lo = new_lo; old_hi = new_hi;
    chg_cyc = cyc; new_lo = cyc + 1; new_hi = cyc + q * Q;
    FC_TX_PAUSEVALID = 1'b1; FC_TX_PAUSEDATA = 16'(q);
    step();
    FC_TX_PAUSEVALID = 1'b0; FC_TX_PAUSEDATA = 16'($urandom);
  endtask

  // Client request raised while the block is idle and unpaused
  task automatic raise_client();
    CLIENT_REQ = 1'b1;
    expect_ev(EV_START, cyc + 1, 0);
  endtask

  // FRAME_DONE at cycle d; the next start comes after the gap plus one IDLE cycle
  task automatic end_frame(input int d, input int ifg, input bit push_start);
    int m;
    m = (ifg == 0) ? 1 : ifg;
    step_to(d);
    FRAME_DONE = 1'b1; TX_IFG_DELAY = 8'(ifg);
    if (push_start) expect_ev(EV_START, d + m + 2, 0);
    step();
    FRAME_DONE = 1'b0; TX_IFG_DELAY = 8'($urandom);
  endtask

  // Play the engine for one client frame. ovr: two pause requests arrive
  // mid-frame (second wins). flt: a link fault is raised mid-frame.
  task automatic serve_frame(input int a, input int len, input int ifg, input bit keep,
                             input bit ovr, input bit flt);
    int s, d, m, e, ifg2;
    logic [15:0] pd;
    pd = '0;
    wait_start(s);
    step_to(s + 1);
    if (a >= 2) FRAME_DONE = 1'b1;          // ignored while waiting for ack
    step_to(s + a);
    FRAME_DONE = 1'b0; TX_ACK = 1'b1;
    expect_ev(EV_GRANT, s + a + 1, 0);
    step();                                   // ACTIVE: stray TX_ACK ignored
    if (flt) begin
      if (urand(0, 1) == 1) LOCALLINKFAULT = 1'b1;
      else                  RXTXLINKFAULT = 1'b1;
    end
    if (ovr) begin PAUSE_REQ = 1'b1; PAUSE_DATA = 16'($urandom); end
    step();
    TX_ACK = 1'b0;
    if (ovr) begin pd = 16'($urandom); PAUSE_DATA = pd; end
    step();
    PAUSE_REQ = 1'b0; PAUSE_DATA = 16'($urandom);
    d = s + a + 1 + len;
    m = (ifg == 0) ? 1 : ifg;
    if (!keep) begin step_to(d); CLIENT_REQ = 1'b0; end
    end_frame(d, ifg, keep && !ovr && !flt);
    if (ovr) begin
      expect_ev(EV_PAUSE, d + m + 2, int'(pd));
      e = d + m + 3 + urand(0, 5);
      ifg2 = urand(0, 7);
      end_frame(e, ifg2, keep);
    end
    if (flt) begin
      step_to(d + m + 1 + urand(1, 10));
      LOCALLINKFAULT = 1'b0; RXTXLINKFAULT = 1'b0;
      if (keep) expect_ev(EV_START, cyc + 1, 0);
    end
  endtask

  initial begin : stim
    int s, p, q, k, d, ifg, m;
    logic [15:0] pd;

    // Reset state
    repeat (3) step();
    @(negedge TX_CLK);
    chk("rst_tx_start", int'(TX_START), 0);
    chk("rst_grant", int'(CLIENT_GRANT), 0);
    chk("rst_pauseval", int'(FC_TRANS_PAUSEVAL), 0);
    chk("rst_pausedata", int'(FC_TRANS_PAUSEDATA), 0);
    chk("rst_paused", int'(PAUSED), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_timeout", int'(TIMEOUT), 0);
    step(); RESET = 1'b0; mon_en = 1'b1; step();

    // Back-to-back client frames: ack 3 cycles in, 40-cycle frame, IFG 5 first
    raise_client();
    serve_frame(3, 40, 5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      serve_frame(urand(1, 8), urand(3, 30), urand(0, 7), i < 4, i == 2, 1'b0);
    repeat (12) step();

    // Received pause holds off the client until the cycle after PAUSED falls
    for (int i = 0; i < 3; i++) begin
      q = (i == 0) ? 30 : urand(1, 12);
      set_pause(q);
      p = chg_cyc;
      raise_client();
      void'(exp_q.pop_back());
      expect_ev(EV_START, p + q * Q + 2, 0);
      serve_frame(urand(1, 5), urand(3, 15), urand(0, 7), 1'b0, 1'b0, 1'b0);
      repeat (12) step();
    end

    // Pause load of 0 releases an ongoing pause at once
    q = urand(20, 60);
    set_pause(q);
    p = chg_cyc;
    CLIENT_REQ = 1'b1;
    step_to(p + 10);
    set_pause(0);
    expect_ev(EV_START, p + 12, 0);
    serve_frame(urand(1, 5), urand(3, 15), urand(0, 7), 1'b0, 1'b0, 1'b0);
    repeat (12) step();

    // Pause request and client request in the same IDLE cycle: pause first
    for (int i = 0; i < 2; i++) begin
      k = cyc;
      pd = (i == 0) ? 16'd30 : 16'($urandom);
      PAUSE_REQ = 1'b1; PAUSE_DATA = pd; CLIENT_REQ = 1'b1;
      expect_ev(EV_PAUSE, k + 1, int'(pd));
      step();
      PAUSE_REQ = 1'b0; PAUSE_DATA = 16'($urandom);
      d = k + 2 + urand(2, 20);
      end_frame(d, urand(0, 7), 1'b1);
      serve_frame(urand(1, 5), urand(3, 15), urand(0, 7), 1'b0, 1'b0, 1'b0);
      repeat (12) step();
    end

    // Ack timeout then retry; then an ack on the very last waiting cycle
    raise_client();
    wait_start(s);
    expect_ev(EV_TIMEOUT, s + TO + 1, 0);
    expect_ev(EV_START, s + TO + 2, 0);
    serve_frame(urand(1, 5), urand(3, 10), urand(0, 3), 1'b0, 1'b0, 1'b0);
    repeat (12) step();
    raise_client();
    serve_frame(TO, 5, 1, 1'b0, 1'b0, 1'b0);
    repeat (12) step();

    // Fault during ACTIVE: frame completes, next start waits for the fault to clear
    for (int i = 0; i < 2; i++) begin
      raise_client();
      serve_frame(urand(1, 5), urand(3, 20), urand(0, 7), 1'b1, 1'b0, 1'b1);
      serve_frame(urand(1, 5), urand(3, 10), urand(0, 7), 1'b0, 1'b0, 1'b0);
      repeat (12) step();
    end

    // Asynchronous reset mid-frame with PAUSED high and a pause request pending
    raise_client();
    wait_start(s);
    step_to(s + 1);
    TX_ACK = 1'b1;
    expect_ev(EV_GRANT, s + 2, 0);
    step();
    TX_ACK = 1'b0;
    set_pause(urand(5, 100));
    PAUSE_REQ = 1'b1; PAUSE_DATA = 16'($urandom);
    step();
    PAUSE_REQ = 1'b0;
    step();
    @(negedge TX_CLK);
    chk("busy_active", int'(BUSY), 1);
    #2;
    mon_en = 1'b0;
    RESET = 1'b1;
    #1;
    chk("arst_tx_start", int'(TX_START), 0);
    chk("arst_grant", int'(CLIENT_GRANT), 0);
    chk("arst_pauseval", int'(FC_TRANS_PAUSEVAL), 0);
    chk("arst_pausedata", int'(FC_TRANS_PAUSEDATA), 0);
    chk("arst_paused", int'(PAUSED), 0);
    chk("arst_busy", int'(BUSY), 0);
    chk("arst_timeout", int'(TIMEOUT), 0);
    chk("queue_before_reset", exp_q.size(), 0);
    old_lo = 1; old_hi = 0; new_lo = 1; new_hi = 0; chg_cyc = 0;
    CLIENT_REQ = 1'b0;
    step(); step();
    RESET = 1'b0;
    step();
    mon_en = 1'b1;
    // Pending flag and pause counter must be gone: a plain client start follows
    raise_client();
    serve_frame(urand(1, 5), urand(3, 10), urand(0, 7), 1'b0, 1'b0, 1'b0);
    repeat (12) step();

    chk("leftover_expectations", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
